i2s_master_port: RTL and testbench

Codec-slave audio serial port. Generates BCLK and LRCK from the system clock and serialises a stereo 16-bit sample pair onto DACDAT in I2S (Philips) format. In the same frame it deserialises ADCDAT into a stereo pair. It is the master-side counterpart to the codec-driven deserialiser/serialiser path, and it sits between the SRAM read/write controllers and the WM8731 pins when the codec is configured as slave.

---
 rtl/audio_pkg.sv | 15 +
 rtl/i2s_master_port_bclk_gen.sv | 44 ++++
 rtl/i2s_master_port.sv | 178 +++++++++++++++++
 tb/tb_i2s_master_port.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and defaults for the I2S master-mode audio port.
package audio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } port_state_t;

  localparam int unsigned DEF_SAMPLE_W = 16;
  localparam int unsigned DEF_SLOT_W   = 32;

  // Philips format: sample MSB follows LRCK change by one BCLK
  localparam int unsigned I2S_DELAY = 1;

endpackage

// File: rtl/i2s_master_port_bclk_gen.sv
// BCLK divider: 50% duty bit clock plus single-cycle rise/fall ticks that
// fire in the cycle before the registered BCLK edge.
module bclk_gen #(
  parameter int unsigned HALF_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic run,
  output logic o_BCLK,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             half_done;

  always_comb begin
    half_done = run && (div_q == DIV_W'(HALF_DIV - 1));
    rise_tick = half_done && !bclk_q;
    fall_tick = half_done && bclk_q;
    div_d     = '0;
    bclk_d    = 1'b0;
    if (run) begin
      div_d  = half_done ? '0 : div_q + DIV_W'(1);
      bclk_d = half_done ? ~bclk_q : bclk_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign o_BCLK = bclk_q;

endmodule

// File: rtl/i2s_master_port.sv
// I2S master port: drives BCLK/LRCK, serialises a stereo DAC pair and
// captures the matching ADC pair in the same frame.
module i2s_master_port
  import audio_pkg::*;
#(
  parameter int unsigned HALF_DIV = 4,
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
  parameter int unsigned SLOT_W   = DEF_SLOT_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [SAMPLE_W-1:0] i_left,
  input  logic [SAMPLE_W-1:0] i_right,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_BCLK,
  output logic                o_LRCK,
  output logic                o_DACDAT,
  input  logic                i_ADCDAT,
  output logic [SAMPLE_W-1:0] o_adc_left,
  output logic [SAMPLE_W-1:0] o_adc_right,
  output logic                o_adc_valid,
  output logic                o_underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_W;
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS);
  localparam int unsigned PAIR_W     = 2 * SAMPLE_W;

  port_state_t         state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PAIR_W-1:0]   hold_q, hold_d;
  logic                full_q, full_d;
  logic                ready_q, ready_d;
  logic [PAIR_W-1:0]   tx_q, tx_d;
  logic [PAIR_W-1:0]   rx_q, rx_d;
  logic                dac_q, dac_d;
  logic                lrck_q, lrck_d;
  logic                under_q, under_d;
  logic                adcv_q, adcv_d;
  logic [SAMPLE_W-1:0] adcl_q, adcl_d;
  logic [SAMPLE_W-1:0] adcr_q, adcr_d;
  logic                run, rise_tick, fall_tick, frame_start, accept;

  // True when the frame bit index falls inside a slot's sample field
  function automatic logic is_data_bit(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] k;
    k = (idx >= IDX_W'(SLOT_W)) ? idx - IDX_W'(SLOT_W) : idx;
    return (k >= IDX_W'(I2S_DELAY)) && (k < IDX_W'(I2S_DELAY + SAMPLE_W));
  endfunction

  assign run = (state_q == RUN);

  bclk_gen #(.HALF_DIV(HALF_DIV)) u_bclk (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .run       (run),
    .o_BCLK    (o_BCLK),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    full_d      = full_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    dac_d       = dac_q;
    lrck_d      = lrck_q;
    adcl_d      = adcl_q;
    adcr_d      = adcr_q;
    under_d     = 1'b0;
    adcv_d      = 1'b0;
    frame_start = 1'b0;
    accept      = i_valid && !full_q;

    case (state_q)
      IDLE: begin
        idx_d  = '0;
        dac_d  = 1'b0;
        lrck_d = 1'b0;
        if (i_enable) begin
          state_d     = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (fall_tick) begin
          if (idx_q == IDX_W'(FRAME_BITS - 1)) begin
            adcl_d = rx_q[PAIR_W-1 -: SAMPLE_W];
            adcr_d = rx_q[SAMPLE_W-1:0];
            adcv_d = 1'b1;
            idx_d  = '0;
            dac_d  = 1'b0;
            lrck_d = 1'b0;
            if (i_enable) frame_start = 1'b1;
            else          state_d     = IDLE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            lrck_d = (idx_d >= IDX_W'(SLOT_W));
            dac_d  = 1'b0;
            if (is_data_bit(idx_d)) begin
              dac_d = tx_q[PAIR_W-1];
              tx_d  = tx_q << 1;
            end
          end
        end
        // ADC bits are taken mid-bit, on the BCLK rising edge
        if (rise_tick && is_data_bit(idx_q)) begin
          rx_d = {rx_q[PAIR_W-2:0], i_ADCDAT};
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_start) begin
      if (full_q) begin
        tx_d   = hold_q;
        full_d = 1'b0;
      end else begin
        tx_d    = '0;
        under_d = 1'b1;
      end
    end

    // A pair accepted on a frame-start cycle waits for the next frame
    if (accept) begin
      hold_d = {i_left, i_right};
      full_d = 1'b1;
    end

    ready_d = !full_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      tx_q    <= '0;
      rx_q    <= '0;
      dac_q   <= 1'b0;
      lrck_q  <= 1'b0;
      under_q <= 1'b0;
      adcv_q  <= 1'b0;
      adcl_q  <= '0;
      adcr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dac_q   <= dac_d;
      lrck_q  <= lrck_d;
      under_q <= under_d;
      adcv_q  <= adcv_d;
      adcl_q  <= adcl_d;
      adcr_q  <= adcr_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_LRCK      = lrck_q;
  assign o_DACDAT    = dac_q;
  assign o_underrun  = under_q;
  assign o_adc_valid = adcv_q;
  assign o_adc_left  = adcl_q;
  assign o_adc_right = adcr_q;

endmodule

// File: tb/tb_i2s_master_port.sv
// Bench for i2s_master_port: frame-level reference model, per-cycle waveform
// comparison and an ADC-pair scoreboard popped on every o_adc_valid strobe.
module tb_i2s_master_port;

  localparam int HALF_DIV   = 2;
  localparam int SAMPLE_W   = 16;
  localparam int SLOT_W     = 32;
  localparam int PAIR_W     = 2 * SAMPLE_W;
  localparam int BIT_CYC    = 2 * HALF_DIV;
  localparam int FRAME_CYC  = 2 * SLOT_W * BIT_CYC;
  localparam int WAIT_LIMIT = 3 * FRAME_CYC;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic valid = 1'b0;
  logic [SAMPLE_W-1:0] left = '0;
  logic [SAMPLE_W-1:0] right = '0;
  logic codec_bit = 1'b0;
  logic loopback = 1'b0;
  logic adcdat;
  logic ready, bclk, lrck, dacdat, adc_v, under;
  logic [SAMPLE_W-1:0] adc_l, adc_r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs_m = 0;
  logic running_m = 1'b0, full_m = 1'b0, adcv_m = 1'b0, under_m = 1'b0;
  logic acc_m = 1'b0, chk_en = 1'b0, was_full = 1'b0, fstart = 1'b0;
  logic [PAIR_W-1:0] hold_m = '0, cur_pair_m = '0, codec_pair_m = '0;
  logic [PAIR_W-1:0] adc_q[$];
  logic [PAIR_W-1:0] adc_exp;
  int c_off, c_p, c_k;
  int d_off, d_p, d_k;
  logic e_bclk, e_lrck, e_dac;

  always #5 clk = ~clk;

  assign adcdat = loopback ? dacdat : codec_bit;

  i2s_master_port #(
    .HALF_DIV (HALF_DIV),
    .SAMPLE_W (SAMPLE_W),
    .SLOT_W   (SLOT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (en),
    .i_left      (left),
    .i_right     (right),
    .i_valid     (valid),
    .o_ready     (ready),
    .o_BCLK      (bclk),
    .o_LRCK      (lrck),
    .o_DACDAT    (dacdat),
    .i_ADCDAT    (adcdat),
    .o_adc_left  (adc_l),
    .o_adc_right (adc_r),
    .o_adc_valid (adc_v),
    .o_underrun  (under)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles (cycle %0d)", name, WAIT_LIMIT, cyc);
  endtask

  // Frame-level reference: frames are FRAME_CYC long from entry to RUN,
  // each consumes the pair held before its start edge or underruns.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_m = 1'b0;
      full_m    = 1'b0;
      adcv_m    = 1'b0;
      under_m   = 1'b0;
      acc_m     = 1'b0;
      adc_q.delete();
    end else begin
      cyc      = cyc + 1;
      was_full = full_m;
      fstart   = 1'b0;
      adcv_m   = 1'b0;
      under_m  = 1'b0;
      acc_m    = 1'b0;
      if (!running_m) begin
        if (en) begin
          running_m = 1'b1;
          fstart    = 1'b1;
        end
      end else if (cyc - fs_m == FRAME_CYC) begin
        adcv_m = 1'b1;
        if (en) fstart = 1'b1;
        else    running_m = 1'b0;
      end
      if (fstart) begin
        fs_m = cyc;
        if (was_full) begin
          cur_pair_m = hold_m;
          full_m     = 1'b0;
        end else begin
          cur_pair_m = '0;
          under_m    = 1'b1;
        end
        codec_pair_m = $urandom;
        adc_q.push_back(loopback ? cur_pair_m : codec_pair_m);
      end
      if (valid && !was_full) begin
        hold_m = {left, right};
        full_m = 1'b1;
        acc_m  = 1'b1;
      end
    end
  end

  // Codec model: presents its ADC word in the data bits, noise elsewhere
  always @(negedge clk) begin
    codec_bit = 1'($urandom);
    if (running_m) begin
      d_off = cyc - fs_m;
      d_p   = d_off / BIT_CYC;
      d_k   = d_p % SLOT_W;
      if (d_k >= 1 && d_k <= SAMPLE_W)
        codec_bit = (d_p < SLOT_W) ? codec_pair_m[PAIR_W - d_k] : codec_pair_m[SAMPLE_W - d_k];
    end
  end

  // Per-cycle waveform/strobe comparison and ADC scoreboard
  always @(negedge clk) begin
    if (chk_en) begin
      e_bclk = 1'b0;
      e_lrck = 1'b0;
      e_dac  = 1'b0;
      if (running_m) begin
        c_off  = cyc - fs_m;
        c_p    = c_off / BIT_CYC;
        c_k    = c_p % SLOT_W;
        e_bclk = (c_off % BIT_CYC) >= HALF_DIV;
        e_lrck = (c_p >= SLOT_W);
        if (c_k >= 1 && c_k <= SAMPLE_W)
          e_dac = (c_p < SLOT_W) ? cur_pair_m[PAIR_W - c_k] : cur_pair_m[SAMPLE_W - c_k];
      end
      check("bclk", bclk, e_bclk);
      check("lrck", lrck, e_lrck);
      check("dacdat", dacdat, e_dac);
      check("ready", ready, !full_m);
      check("underrun", under, under_m);
      check("adc_valid", adc_v, adcv_m);
      if (adc_v === 1'b1) begin
        if (adc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL adc_pair: strobe with pair %h, expected no strobe", {adc_l, adc_r});
        end else begin
          adc_exp = adc_q.pop_front();
          check("adc_pair", {adc_l, adc_r}, adc_exp);
        end
      end
    end
  end

  // Drive a pair until the model accepts it; returns on a negedge
  task automatic offer(input logic [PAIR_W-1:0] pr);
    int n;
    n = 0;
    valid = 1'b1;
    {left, right} = pr;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!acc_m && n < WAIT_LIMIT);
    if (!acc_m) timeout_fail("offer");
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Advance to the next negedge at the given cycle offset within a frame
  task automatic wait_off(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(running_m && (cyc - fs_m == target)) && n < WAIT_LIMIT);
    if (!(running_m && (cyc - fs_m == target))) timeout_fail("wait_off");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (running_m && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (running_m) timeout_fail("wait_idle");
  endtask

  initial begin
    // Reset, then a long idle stretch with the clock stopped
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_adc_out", {adc_l, adc_r}, 32'h0);
    repeat (100) @(negedge clk);

    // TX format, loopback and back-to-back offers
    loopback = 1'b1;
    offer(32'hA5F0_0001);
    en = 1'b1;
    offer($urandom);
    offer($urandom);
    offer($urandom);
    wait_off(FRAME_CYC - 1);
    wait_off(FRAME_CYC - 1);
    wait_off(10 * BIT_CYC);
    en = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // Underrun frames, then a pair offered exactly on a frame-start edge
    loopback = 1'b0;
    en = 1'b1;
    wait_off(FRAME_CYC - 1);
    wait_off(FRAME_CYC - 1);
    wait_off(FRAME_CYC - 1);
    offer($urandom);
    wait_off(FRAME_CYC - 1);
    wait_off(10 * BIT_CYC);
    en = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // Asynchronous reset in the right slot
    loopback = 1'b1;
    offer($urandom);
    en = 1'b1;
    wait_off(40 * BIT_CYC);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_bclk", bclk, 1'b0);
    check("async_rst_lrck", lrck, 1'b0);
    check("async_rst_dac", dacdat, 1'b0);
    check("async_rst_ready", ready, 1'b1);
    check("async_rst_adcv", adc_v, 1'b0);
    check("async_rst_adc", {adc_l, adc_r}, 32'h0);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Random pairs with random gaps, codec supplying random ADC words
    loopback = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 300)) @(negedge clk);
      offer($urandom);
    end
    wait_off(FRAME_CYC - 1);
    wait_off(FRAME_CYC - 1);
    wait_off($urandom_range(1, FRAME_CYC - 2));
    en = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    check("adc_queue_drained", adc_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
